// File: rtl/fpdiv_ctrl_if.sv
// Handshake and datapath-control bundle between an FP unit (master) and the
// Goldschmidt divider sequencer (slave).
interface fpdiv_ctrl_if #(
    parameter int CW = 4
);
    logic          start;
    logic          abort;
    logic [1:0]    sel_mux3;
    logic [1:0]    sel_mux4;
    logic          en_a;
    logic          en_b;
    logic          en_rem;
    logic          busy;
    logic          done;
    logic [CW-1:0] iter;

    modport master (
        output start, abort,
        input  sel_mux3, sel_mux4, en_a, en_b, en_rem, busy, done, iter
    );

    modport slave (
        input  start, abort,
        output sel_mux3, sel_mux4, en_a, en_b, en_rem, busy, done, iter
    );
endinterface

// File: rtl/fpdiv_ctrl.sv
// Sequencer for the Goldschmidt divider: IA seed iteration, ITERS-1 refinement
// iterations, a remainder-capture cycle, then a one-cycle done pulse.
module fpdiv_ctrl #(
    parameter int ITERS = 6,
    parameter int CW    = 4
) (
    input  logic         clk,
    input  logic         reset,
    fpdiv_ctrl_if.slave  bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_NUM  = 3'd1;
    localparam logic [2:0] S_DEN  = 3'd2;
    localparam logic [2:0] S_REM  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [CW-1:0] ITER_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ITER_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] LAST_IT   = CW'(ITERS - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] iter_q, iter_d;
    logic [1:0]    sel_mux3_q, sel_mux3_d;
    logic [1:0]    sel_mux4_q, sel_mux4_d;
    logic          en_a_q, en_a_d;
    logic          en_b_q, en_b_d;
    logic          en_rem_q, en_rem_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          first_s;

    // Next-state and iteration-counter logic; abort overrides everything.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        if (bus.abort) begin
            state_d = S_IDLE;
            iter_d  = ITER_ZERO;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = bus.start ? S_NUM : S_IDLE;
                    iter_d  = ITER_ZERO;
                end
                S_NUM: begin
                    state_d = S_DEN;
                end
                S_DEN: begin
                    if (iter_q == LAST_IT) begin
                        state_d = S_REM;
                    end else begin
                        state_d = S_NUM;
                        iter_d  = iter_q + ITER_ONE;
                    end
                end
                S_REM: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                    iter_d  = ITER_ZERO;
                end
            endcase
        end
    end

    // Decode the upcoming state so the outputs can be registered yet stay Moore-timed.
    always_comb begin
        first_s    = (iter_d == ITER_ZERO);
        sel_mux3_d = 2'b00;
        sel_mux4_d = 2'b00;
        en_a_d     = 1'b0;
        en_b_d     = 1'b0;
        en_rem_d   = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_d)
            S_NUM: begin
                en_a_d     = 1'b1;
                busy_d     = 1'b1;
                sel_mux4_d = first_s ? 2'b00 : 2'b10;
                sel_mux3_d = first_s ? 2'b00 : 2'b01;
            end
            S_DEN: begin
                en_b_d     = 1'b1;
                busy_d     = 1'b1;
                sel_mux4_d = first_s ? 2'b01 : 2'b11;
                sel_mux3_d = first_s ? 2'b00 : 2'b01;
            end
            S_REM: begin
                en_rem_d   = 1'b1;
                busy_d     = 1'b1;
                sel_mux4_d = 2'b10;
                sel_mux3_d = 2'b10;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // State, counter and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            iter_q     <= ITER_ZERO;
            sel_mux3_q <= 2'b00;
            sel_mux4_q <= 2'b00;
            en_a_q     <= 1'b0;
            en_b_q     <= 1'b0;
            en_rem_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            sel_mux3_q <= sel_mux3_d;
            sel_mux4_q <= sel_mux4_d;
            en_a_q     <= en_a_d;
            en_b_q     <= en_b_d;
            en_rem_q   <= en_rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.sel_mux3 = sel_mux3_q;
    assign bus.sel_mux4 = sel_mux4_q;
    assign bus.en_a     = en_a_q;
    assign bus.en_b     = en_b_q;
    assign bus.en_rem   = en_rem_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.iter     = iter_q;
endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Self-checking bench for fpdiv_ctrl: the reference model tracks the position
// within the divide schedule and derives the expected controls arithmetically.
module tb_fpdiv_ctrl;
    localparam int ITERS = 6;
    localparam int CW    = 4;
    localparam int REMP  = 2 * ITERS + 1;
    localparam int DONEP = 2 * ITERS + 2;
    localparam int OW    = 9 + CW;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   p     = 0;
    int   cyc_n = 0;

    fpdiv_ctrl_if #(.CW(CW)) bus ();

    fpdiv_ctrl #(.ITERS(ITERS), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    wire [OW-1:0] obs = {bus.sel_mux4, bus.sel_mux3, bus.en_a, bus.en_b,
                         bus.en_rem, bus.busy, bus.done, bus.iter};

    // Expected {sel_mux4, sel_mux3, en_a, en_b, en_rem, busy, done, iter} at schedule position pos.
    function automatic logic [OW-1:0] expect_of(input int pos);
        logic [1:0] m4 = 2'b00;
        logic [1:0] m3 = 2'b00;
        logic ea = 1'b0, eb = 1'b0, er = 1'b0, bz = 1'b0, dn = 1'b0;
        int it = 0;
        if (pos >= 1 && pos <= 2 * ITERS) begin
            it = (pos - 1) / 2;
            bz = 1'b1;
            if ((pos - 1) % 2 == 0) begin
                ea = 1'b1;
                m4 = (it == 0) ? 2'b00 : 2'b10;
            end else begin
                eb = 1'b1;
                m4 = (it == 0) ? 2'b01 : 2'b11;
            end
            m3 = (it == 0) ? 2'b00 : 2'b01;
        end else if (pos == REMP) begin
            m4 = 2'b10; m3 = 2'b10; er = 1'b1; bz = 1'b1; it = ITERS - 1;
        end else if (pos == DONEP) begin
            dn = 1'b1; it = ITERS - 1;
        end
        return {m4, m3, ea, eb, er, bz, dn, CW'(it)};
    endfunction

    // Drive inputs, advance one clock, update the model, settle at the falling edge.
    task automatic tick(input logic s, input logic a);
        bus.start = s;
        bus.abort = a;
        @(posedge clk);
        if (a) p = 0;
        else if (p == 0 || p == DONEP) p = s ? 1 : 0;
        else p = p + 1;
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; p = 0;
        repeat (2) @(negedge clk);
        tests++;
        if (obs !== {OW{1'b0}}) begin
            fails++; $display("FAIL reset_hold: got %b expected %b", obs, {OW{1'b0}});
        end
        reset = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick(1'b0, 1'b0);
            tests++;
            if (obs !== expect_of(p)) begin
                fails++; $display("FAIL reset_idle cyc %0d: got %b expected %b", n, obs, expect_of(p));
            end
        end
    endtask

    task automatic test_single();
        int busy_cnt = 0;
        int done_at  = -1;
        tick(1'b1, 1'b0);
        for (int n = 1; n <= DONEP + 2; n++) begin
            tests++;
            if (obs !== expect_of(p)) begin
                fails++; $display("FAIL single cyc k+%0d: got %b expected %b", n, obs, expect_of(p));
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) done_at = n;
            tick(1'b0, 1'b0);
        end
        tests++;
        if (busy_cnt !== 2 * ITERS + 1) begin
            fails++; $display("FAIL single_busy_len: got %0d expected %0d", busy_cnt, 2 * ITERS + 1);
        end
        tests++;
        if (done_at !== DONEP) begin
            fails++; $display("FAIL single_done_cycle: got %0d expected %0d", done_at, DONEP);
        end
    endtask

    task automatic test_back_to_back();
        int last_done = -1;
        int n_done    = 0;
        for (int n = 0; n < 3 * DONEP + 2; n++) begin
            tick(1'b1, 1'b0);
            tests++;
            if (obs !== expect_of(p)) begin
                fails++; $display("FAIL b2b cyc %0d: got %b expected %b", n, obs, expect_of(p));
            end
            if (bus.done) begin
                n_done++;
                if (last_done >= 0) begin
                    tests++;
                    if (cyc_n - last_done !== DONEP) begin
                        fails++; $display("FAIL b2b_interval: got %0d expected %0d", cyc_n - last_done, DONEP);
                    end
                end
                last_done = cyc_n;
            end
        end
        tests++;
        if (n_done < 3) begin
            fails++; $display("FAIL b2b_done_count: got %0d expected >=3", n_done);
        end
        tick(1'b0, 1'b1);
    endtask

    task automatic test_abort();
        int done_at = -1;
        tick(1'b1, 1'b0);
        for (int n = 0; n < 20 && p != 8; n++) tick(1'b0, 1'b0);
        tests++;
        if (bus.iter !== CW'(3) || bus.en_b !== 1'b1 || obs !== expect_of(p)) begin
            fails++; $display("FAIL abort_den3: got %b expected %b", obs, expect_of(8));
        end
        tick(1'b0, 1'b1);
        tests++;
        if (obs !== {OW{1'b0}} || bus.busy !== 1'b0) begin
            fails++; $display("FAIL abort_idle: got %b expected %b", obs, {OW{1'b0}});
        end
        for (int n = 0; n < 20; n++) begin
            tick(1'b0, 1'b0);
            tests++;
            if (bus.done !== 1'b0 || obs !== expect_of(p)) begin
                fails++; $display("FAIL abort_no_done cyc %0d: got %b expected %b", n, obs, expect_of(p));
            end
        end
        tick(1'b1, 1'b0);
        for (int n = 1; n <= DONEP; n++) begin
            tests++;
            if (obs !== expect_of(p)) begin
                fails++; $display("FAIL abort_rerun cyc %0d: got %b expected %b", n, obs, expect_of(p));
            end
            if (bus.done) done_at = n;
            tick(1'b0, 1'b0);
        end
        tests++;
        if (done_at !== DONEP) begin
            fails++; $display("FAIL abort_rerun_done: got %0d expected %0d", done_at, DONEP);
        end
    endtask

    task automatic test_ignored_start();
        int done_at = -1;
        tick(1'b1, 1'b0);
        for (int n = 1; n <= DONEP; n++) begin
            tests++;
            if (obs !== expect_of(p)) begin
                fails++; $display("FAIL ignored_start cyc %0d: got %b expected %b", n, obs, expect_of(p));
            end
            if (bus.done) done_at = n;
            tick((p == DONEP) ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0);
        end
        tests++;
        if (done_at !== DONEP) begin
            fails++; $display("FAIL ignored_start_done: got %0d expected %0d", done_at, DONEP);
        end
        for (int n = 0; n < 4; n++) begin
            tick(1'b1, 1'b1);
            tests++;
            if (obs !== {OW{1'b0}}) begin
                fails++; $display("FAIL abort_priority cyc %0d: got %b expected %b", n, obs, {OW{1'b0}});
            end
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        tick(1'b1, 1'b0);
        for (int n = 0; n < 20 && p != 5; n++) tick(1'b0, 1'b0);
        tests++;
        if (bus.iter !== CW'(2) || bus.en_a !== 1'b1 || obs !== expect_of(p)) begin
            fails++; $display("FAIL async_pre_num2: got %b expected %b", obs, expect_of(5));
        end
        #2 reset = 1'b0;
        #1;
        p = 0;
        tests++;
        if (obs !== {OW{1'b0}}) begin
            fails++; $display("FAIL async_reset_immediate: got %b expected %b", obs, {OW{1'b0}});
        end
        @(negedge clk);
        reset = 1'b1;
        tick(1'b0, 1'b0);
        tests++;
        if (obs !== expect_of(p)) begin
            fails++; $display("FAIL async_post_idle: got %b expected %b", obs, expect_of(p));
        end
        tick(1'b1, 1'b0);
        for (int n = 1; n <= DONEP; n++) begin
            tests++;
            if (obs !== expect_of(p)) begin
                fails++; $display("FAIL async_restart cyc %0d: got %b expected %b", n, obs, expect_of(p));
            end
            tick(1'b0, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
            tests++;
            if (obs !== expect_of(p)) begin
                fails++; $display("FAIL random cyc %0d: got %b expected %b", n, obs, expect_of(p));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_ignored_start();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fpdiv_ctrl.md
Name: fpdiv_ctrl

Overview:
Sequencing FSM for the Goldschmidt divider datapath fpdiv. It replaces hand-driven mux selects and register enables with an automatic schedule. The schedule is:
- one seed iteration using the initial approximation (IA);
- ITERS-1 refinement iterations using the C-register correction factor;
- a final remainder-capture cycle.
A start/busy/done handshake lets a higher-level FP unit issue back-to-back divides.

Parameters:
ITERS, 6, total iterations including the IA seed iteration; legal range 1..15.
CW, 4, iteration counter width; must satisfy 2**CW > ITERS.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous active-low reset (0 = reset asserted)
start  input  1  request a divide; sampled only in IDLE or DONE
abort  input  1  synchronous cancel; returns to IDLE next edge
sel_mux3  output  2  fpdiv multiplicand select: 00 = IA, 01 = C reg, 10 = remainder path
sel_mux4  output  2  fpdiv operand select: 00 = num×IA, 01 = den×IA, 10 = A-path refine, 11 = B-path refine
en_a  output  1  load enable, fpdiv register A (numerator path)
en_b  output  1  load enable, fpdiv register B (denominator path)
en_rem  output  1  load enable, remainder register
busy  output  1  high from the first iteration cycle through the REM cycle
done  output  1  one-cycle pulse in the DONE state
iter  output  CW  current iteration index, 0-based

Behaviour:
- States: IDLE, NUM, DEN, REM, DONE.
- Outputs are Moore, decoded from the registered state and iteration counter; no combinational path from any input to any output.
- Reset (reset=0, asynchronous), and IDLE outputs:
  - state=IDLE, iter=0;
  - sel_mux3=00, sel_mux4=00;
  - en_a=en_b=en_rem=0, busy=0, done=0.
- IDLE: start=1 -> NUM with iter=0; otherwise hold.
- NUM outputs:
  - en_a=1, en_b=0, en_rem=0;
  - sel_mux4=00 and sel_mux3=00 when iter==0;
  - sel_mux4=10 and sel_mux3=01 when iter>0.
  - Next state: DEN.
- DEN outputs:
  - en_b=1, en_a=0;
  - sel_mux4=01 and sel_mux3=00 when iter==0;
  - sel_mux4=11 and sel_mux3=01 otherwise.
  - If iter==ITERS-1 -> REM; else iter<=iter+1 -> NUM.
- REM outputs: sel_mux4=10, sel_mux3=10, en_rem=1, en_a=en_b=0, busy=1. Next state: DONE.
- DONE outputs: done=1, busy=0, all enables 0, selects 00.
  - start=1 -> NUM with iter=0 (back-to-back divides allowed);
  - else -> IDLE.
- busy=1 in NUM, DEN and REM only.
- Latency: start sampled high at edge k.
  - NUM/DEN alternate during cycles k+1 .. k+2*ITERS.
  - REM occupies cycle k+2*ITERS+1.
  - done is high during cycle k+2*ITERS+2.
  - For ITERS=6: 12 iteration cycles, REM in the 13th, done in the 14th.
- start while busy: ignored, no queuing.
- abort=1 in any state -> IDLE, iter=0 at the next edge. The enable outputs of the current cycle still apply, since they are Moore outputs. No done pulse is generated. abort has priority over start.
- ITERS=1: sequence is NUM(00/00), DEN(01/00), REM, DONE. Refine codes 10/11 never appear on sel_mux4 with sel_mux3=01.
- Exactly one of en_a, en_b, en_rem is high in NUM, DEN and REM. None is high in IDLE or DONE.
- iter never exceeds ITERS-1. The counter holds its value in REM and DONE and clears on entry to NUM from IDLE or DONE.
- Reset asserted mid-operation: immediate asynchronous return to IDLE values. Operation resumes only on a new start after reset deasserts.

Test Plan:
1. Reset: hold reset=0 for 2 cycles, then release -> all outputs 0 and iter=0; with start=0 the block stays in IDLE indefinitely.
2. Single divide, ITERS=6: start pulse at edge k.
   - Cycle k+1 (iter=0): sel_mux4/sel_mux3/en_a/en_b = 00/00/1/0.
   - Cycle k+2 (iter=0): 01/00/0/1.
   - Cycles k+3..k+12: alternate 10/01/1/0 and 11/01/0/1, with iter stepping 1..5.
   - Cycle k+13: REM, 10/10 with en_rem=1.
   - Cycle k+14: done=1, busy=0.
   - Check busy high for exactly 13 cycles.
3. Back-to-back: hold start=1 continuously -> DONE is followed directly by NUM with iter=0; done pulses every 14 cycles; no IDLE cycle appears between divides.
4. Abort: assert abort during DEN with iter=3 -> next cycle is IDLE, busy=0, no done pulse; a subsequent start runs a full 14-cycle sequence.
5. Ignored start and abort priority:
   - Toggle start while busy -> schedule is unchanged.
   - Assert start and abort together in IDLE -> block stays in IDLE.
6. Async reset mid-run: drive reset=0 between clock edges during NUM with iter=2 -> outputs go to 0 immediately, without waiting for a clock edge; release reset, then start -> sequence restarts at iter=0.
